// File: rtl/graphics_draw_scheduler_pkg.sv
// Shared types and constants for the graphics draw scheduler.
// State encoding, asset index width and default timing values.
package graphics_draw_scheduler_pkg;

  localparam int ASSET_W            = 3;
  localparam int DEF_NUM_ASSETS     = 8;
  localparam int DEF_REFRESH_CYCLES = 5000000;
  localparam int DEF_TIMEOUT_CYCLES = 8191;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ERASE   = 3'd1,
    ST_SELECT  = 3'd2,
    ST_UPGRADE = 3'd3,
    ST_MONEY   = 3'd4
  } state_t;

endpackage

// File: rtl/graphics_draw_scheduler_draw_priority_pick.sv
// Lowest-set-bit finder over the pending upgrade bitmap.
// Returns the index of the lowest pending building and a valid flag.
module draw_priority_pick #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     pend,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pend[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/graphics_draw_scheduler.sv
// Serialises selection, upgrade and money draw requests into one datapath
// command at a time, with completion handshake, watchdog and money refresh.
module graphics_draw_scheduler
  import graphics_draw_scheduler_pkg::*;
#(
  parameter int NUM_ASSETS     = DEF_NUM_ASSETS,
  parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sel_req,
  input  logic [ASSET_W-1:0] sel_asset,
  input  logic               upg_req,
  input  logic [ASSET_W-1:0] upg_asset,
  input  logic               money_req,
  input  logic               draw_done,
  output logic               drawSelection,
  output logic               drawUpgrade,
  output logic               drawMoney,
  output logic               black,
  output logic [7:0]         selectedAsset,
  output logic               busy,
  output logic               timeout_err
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] REFRESH_LAST = 32'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);

  state_t state, state_next;

  logic                  pend_sel, pend_erase, pend_money;
  logic [NUM_ASSETS-1:0] pend_upg, upg_set, upg_clr;
  logic [ASSET_W-1:0]    cur_asset, cmd_asset, drawn_asset, upg_idx;
  logic                  drawn_valid, upg_valid;
  logic                  take_erase, take_sel, take_upg, take_money, timeout_hit;
  logic [31:0]           refresh_cnt;
  logic                  refresh_hit;
  logic [WD_W-1:0]       wd_cnt;

  draw_priority_pick #(
    .N     (NUM_ASSETS),
    .IDX_W (ASSET_W)
  ) u_pick (
    .pend  (pend_upg),
    .idx   (upg_idx),
    .valid (upg_valid)
  );

  assign refresh_hit = (REFRESH_CYCLES != 0) && (refresh_cnt == REFRESH_LAST);

  always_comb begin
    upg_set = '0;
    upg_clr = '0;
    for (int i = 0; i < NUM_ASSETS; i++) begin
      if (upg_req && (upg_asset == ASSET_W'(i))) upg_set[i] = 1'b1;
      if (take_upg && (upg_idx == ASSET_W'(i))) upg_clr[i] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // draw_done has precedence over a watchdog expiry in the same cycle.
  always_comb begin
    state_next  = state;
    take_erase  = 1'b0;
    take_sel    = 1'b0;
    take_upg    = 1'b0;
    take_money  = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pend_erase) begin
          state_next = ST_ERASE;
          take_erase = 1'b1;
        end else if (pend_sel) begin
          state_next = ST_SELECT;
          take_sel   = 1'b1;
        end else if (upg_valid) begin
          state_next = ST_UPGRADE;
          take_upg   = 1'b1;
        end else if (pend_money) begin
          state_next = ST_MONEY;
          take_money = 1'b1;
        end
      end
      default: begin
        if (draw_done) begin
          state_next = ST_IDLE;
        end else if (wd_cnt == WD_LAST) begin
          state_next  = ST_IDLE;
          timeout_hit = 1'b1;
        end
      end
    endcase
  end

  assign drawSelection = (state == ST_ERASE) || (state == ST_SELECT);
  assign black         = (state == ST_ERASE);
  assign drawUpgrade   = (state == ST_UPGRADE);
  assign drawMoney     = (state == ST_MONEY);
  assign busy          = (state != ST_IDLE);
  assign selectedAsset = {{(8 - ASSET_W){1'b0}}, cmd_asset};

  // A new selection while the box is being drawn must erase that box first.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_sel    <= 1'b0;
      pend_erase  <= 1'b0;
      pend_money  <= 1'b0;
      pend_upg    <= '0;
      cur_asset   <= '0;
      cmd_asset   <= '0;
      drawn_asset <= '0;
      drawn_valid <= 1'b0;
      refresh_cnt <= '0;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (sel_req) begin
        cur_asset  <= sel_asset;
        pend_sel   <= 1'b1;
        pend_erase <= drawn_valid || (state == ST_SELECT);
      end else begin
        if (take_sel)   pend_sel   <= 1'b0;
        if (take_erase) pend_erase <= 1'b0;
      end

      pend_upg <= (pend_upg & ~upg_clr) | upg_set;

      if (money_req || refresh_hit) pend_money <= 1'b1;
      else if (take_money)          pend_money <= 1'b0;

      if (refresh_hit || (REFRESH_CYCLES == 0)) refresh_cnt <= '0;
      else                                      refresh_cnt <= refresh_cnt + 32'd1;

      if (take_erase)    cmd_asset <= drawn_asset;
      else if (take_sel) cmd_asset <= cur_asset;
      else if (take_upg) cmd_asset <= upg_idx;

      if ((state == ST_SELECT) && draw_done) begin
        drawn_asset <= cmd_asset;
        drawn_valid <= 1'b1;
      end

      if (state == ST_IDLE) wd_cnt <= '0;
      else                  wd_cnt <= wd_cnt + WD_W'(1);

      if (timeout_hit) timeout_err <= 1'b1;
    end
  end

endmodule

// File: doc/graphics_draw_scheduler.md
Name: graphics_draw_scheduler

Overview:
- Controller in front of graphicsDatapath. Collects draw requests from game logic and serialises them into one datapath command at a time: selection erase, selection box, upgrade sprite and money field.
- Drives drawSelection / drawUpgrade / drawMoney / black and selectedAsset.
- Holds each command until the datapath reports completion or a watchdog expires.
- Also generates a periodic money-refresh request.

Parameters:
- NUM_ASSETS, 8, number of buildings; width of the upgrade pending bitmap.
- REFRESH_CYCLES, 5000000, clock cycles between automatic money redraws (0 disables).
- TIMEOUT_CYCLES, 8191, maximum cycles a command may stay outstanding. Must exceed 75x75 plus overhead.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- sel_req  in  1  one-cycle pulse: cursor moved
- sel_asset  in  3  new cursor index, sampled with sel_req
- upg_req  in  1  one-cycle pulse: building upgraded
- upg_asset  in  3  upgraded index, sampled with upg_req
- money_req  in  1  one-cycle pulse: balance changed
- draw_done  in  1  one-cycle pulse from datapath: current command finished
- drawSelection  out  1  selection-box command level
- drawUpgrade  out  1  upgrade-sprite command level
- drawMoney  out  1  money-field command level
- black  out  1  qualifies drawSelection as erase
- selectedAsset  out  8  asset index for current command (upper 5 bits 0)
- busy  out  1  high whenever state != IDLE
- timeout_err  out  1  sticky, set on watchdog expiry

Behaviour:
- Reset: all outputs 0; state IDLE; all pending flags clear; drawn_valid=0; refresh and watchdog counters 0.
- Request capture (every cycle, any state):
  - sel_req: cur_asset<=sel_asset; pend_sel<=1; pend_erase<=drawn_valid.
  - upg_req: pend_upg[upg_asset]<=1 (bitmap; duplicates merge).
  - money_req or refresh counter reaching REFRESH_CYCLES-1: pend_money<=1; counter wraps to 0.
  - A request and service of the same flag in the same cycle: the request wins, so the flag stays set.
- FSM states: IDLE, ERASE, SELECT, UPGRADE, MONEY.
- IDLE: pick by fixed priority erase > select > upgrade (lowest set index) > money.
  - Pending flag clears on entry.
  - Command outputs assert the cycle after the decision.
- Per-state command encoding:
  - ERASE: drawSelection=1, black=1, selectedAsset=drawn_asset.
  - SELECT: drawSelection=1, black=0, selectedAsset=cur_asset latched on entry.
  - UPGRADE: drawUpgrade=1, selectedAsset=chosen index.
  - MONEY: drawMoney=1, selectedAsset unchanged.
- Command hold: outputs are held constant for the whole state; a later sel_req never alters selectedAsset mid-command.
- Completion on draw_done:
  - Return to IDLE, deassert commands the same edge, then one idle cycle minimum between commands.
  - SELECT completion: drawn_asset<=selectedAsset[2:0]; drawn_valid<=1.
  - draw_done in IDLE is ignored.
- Watchdog: counts while non-IDLE, clears on entry.
  - At TIMEOUT_CYCLES: force IDLE, set timeout_err. The aborted request is not re-queued.
  - timeout_err clears only on reset.
- Back-to-back selection: a new sel_req during SELECT re-sets pend_sel and pend_erase. The newly drawn box is then erased before the new one is drawn.
- Reset mid-command: outputs drop on the reset edge; the datapath is expected to return to its idle step within one draw.

Decomposition:
- Shared package: state encoding constants (IDLE=0..MONEY=4), asset index width (3), default timing constants.
- One natural sub-module: draw_priority_pick. Combinational lowest-set-bit finder over pend_upg returning index and valid.
- Counters and FSM stay in the top module.

Test Plan:
- Reset, then single sel_req asset=2, draw_done after 10 cycles -> one SELECT with selectedAsset=2, black=0, no ERASE; drawn_asset=2; busy falls with draw_done.
- After the first test, sel_req asset=5 -> ERASE with selectedAsset=2, black=1, then SELECT with selectedAsset=5.
- upg_req 6, 1, 6 while busy with MONEY -> after MONEY, UPGRADE asset 1 then asset 6, exactly two upgrades.
- sel_req, upg_req 3, money_req in the same cycle from IDLE -> order SELECT, UPGRADE(3), MONEY; each command held stable until its draw_done.
- draw_done withheld in UPGRADE -> forced IDLE at cycle TIMEOUT_CYCLES; timeout_err=1 and stays 1; next pending request is then serviced.
- REFRESH_CYCLES=100, no inputs -> drawMoney command begins every 100 cycles; reset mid-MONEY -> all outputs 0 the next cycle.
